// File: rtl/dmux_pkg.sv
// dmux_pkg: buffer state encoding and destination select codes shared by the demux stage
package dmux_pkg;
  typedef logic [1:0] buf_state_t;
  localparam buf_state_t BUF_EMPTY = 2'd0;
  localparam buf_state_t BUF_ONE   = 2'd1;
  localparam buf_state_t BUF_FULL  = 2'd2;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/dmux_fifo2.sv
// dmux_fifo2: 2-entry elastic buffer; r_d0 always holds the oldest word so o_data needs no mux
module dmux_fifo2
  import dmux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_full,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  buf_state_t       r_state;
  logic [WIDTH-1:0] r_d0, r_d1;
  logic             w_push, w_pop;
  assign o_valid = r_state != BUF_EMPTY;
  assign o_full  = r_state == BUF_FULL;
  assign o_data  = r_d0;
  assign w_pop   = o_valid && i_ready;
  assign w_push  = i_push && !o_full;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= BUF_EMPTY;
      r_d0    <= '0;
      r_d1    <= '0;
    end else begin
      r_state <= (w_push && !w_pop) ? (o_valid ? BUF_FULL : BUF_ONE) :
                 (w_pop && !w_push) ? (o_full ? BUF_ONE : BUF_EMPTY) : r_state;
      r_d0    <= w_pop ? (o_full ? r_d1 : i_data) : (w_push && !o_valid) ? i_data : r_d0;
      r_d1    <= (w_push && o_valid && !w_pop) ? i_data : r_d1;
    end
endmodule

// File: rtl/dmux_stream.sv
// dmux_stream: registered 1-to-2 stream demux with a 2-entry buffer per output.
// Optional per-output delivery counters are built when DMUX_STREAM_COUNT_EN is defined.
module dmux_stream
  import dmux_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_sel,
  output logic               a_valid,
  input  logic               a_ready,
  output logic [WIDTH-1:0]   a_data,
  output logic               b_valid,
  input  logic               b_ready,
  output logic [WIDTH-1:0]   b_data,
  output logic [COUNT_W-1:0] a_count,
  output logic [COUNT_W-1:0] b_count
);
  logic w_full_a, w_full_b, w_push_a, w_push_b;
  // in_ready looks only at the selected buffer's state, never at the consumer readies
  assign in_ready = (in_sel == SEL_B) ? !w_full_b : !w_full_a;
  assign w_push_a = in_valid && in_ready && (in_sel == SEL_A);
  assign w_push_b = in_valid && in_ready && (in_sel == SEL_B);
  dmux_fifo2 #(.WIDTH(WIDTH)) u_fifo_a (
    .clk(clk), .reset(reset), .i_push(w_push_a), .i_data(in_data), .i_ready(a_ready),
    .o_full(w_full_a), .o_valid(a_valid), .o_data(a_data)
  );
  dmux_fifo2 #(.WIDTH(WIDTH)) u_fifo_b (
    .clk(clk), .reset(reset), .i_push(w_push_b), .i_data(in_data), .i_ready(b_ready),
    .o_full(w_full_b), .o_valid(b_valid), .o_data(b_data)
  );
`ifdef DMUX_STREAM_COUNT_EN
  logic [COUNT_W-1:0] r_a_count, r_b_count;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_a_count <= '0;
      r_b_count <= '0;
    end else begin
      r_a_count <= (a_valid && a_ready) ? r_a_count + COUNT_W'(1) : r_a_count;
      r_b_count <= (b_valid && b_ready) ? r_b_count + COUNT_W'(1) : r_b_count;
    end
  assign a_count = r_a_count;
  assign b_count = r_b_count;
`else
  assign a_count = '0;
  assign b_count = '0;
`endif
endmodule

// File: tb/tb_dmux_stream.sv
// tb_dmux_stream: directed and randomized checks of dmux_stream against a queue-based model
module tb_dmux_stream;
  logic       clk = 0, reset = 1, in_valid = 0, in_sel = 0, a_ready = 0, b_ready = 0;
  logic [7:0] in_data = 0;
  logic       in_ready, a_valid, b_valid;
  logic [7:0] a_data, b_data;
  logic [3:0] a_count, b_count;
  int         checks = 0, errors = 0, na = 0, nb = 0;
  logic [7:0] qa[$], qb[$];
`ifdef DMUX_STREAM_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  always #5 clk = ~clk;
  dmux_stream #(.WIDTH(8), .COUNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .a_count(a_count), .b_count(b_count)
  );
  function automatic logic [3:0] exp_cnt(int n);
    return CNT_EN ? 4'(n % 16) : 4'd0;
  endfunction
  task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic ar, input logic br);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    #1;
  endtask
  // Model: each output is a queue of at most two words; pops happen before the push lands
  task automatic step();
    bit acc, pa, pb, s;
    logic [7:0] d;
    acc = in_valid && (in_sel ? qb.size() < 2 : qa.size() < 2);
    pa  = a_ready && qa.size() > 0;
    pb  = b_ready && qb.size() > 0;
    s   = in_sel;
    d   = in_data;
    @(posedge clk);
    if (pa) begin void'(qa.pop_front()); na++; end
    if (pb) begin void'(qb.pop_front()); nb++; end
    if (acc) begin if (s) qb.push_back(d); else qa.push_back(d); end
    #1;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    qa.delete();
    qb.delete();
    na = 0;
    nb = 0;
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_valid, b_valid, a_data, b_data, a_count, b_count} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs got av=%b bv=%b ad=%h bd=%h ac=%h bc=%h want all zero", a_valid, b_valid, a_data, b_data, a_count, b_count);
    end
    reset = 0;
    drive(0, 0, 0, 0, 0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_a got %b want 1", in_ready); end
    drive(0, 1, 0, 0, 0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_b got %b want 1", in_ready); end
  endtask
  task automatic test_single();
    drive(1, 0, 8'h5A, 0, 0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b want 1", in_ready); end
    step();
    checks++;
    if (a_valid !== 1'b1 || a_data !== 8'h5A || b_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_word got av=%b ad=%h bv=%b want av=1 ad=5a bv=0", a_valid, a_data, b_valid);
    end
    drive(0, 0, 0, 1, 0);
    step();
    checks++;
    if (a_valid !== 1'b0) begin errors++; $display("FAIL single_drain got av=%b want 0", a_valid); end
  endtask
  task automatic test_back_pressure();
    drive(1, 0, 8'h01, 0, 0);
    step();
    drive(1, 0, 8'h02, 0, 0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after1 got %b want 1", in_ready); end
    step();
    drive(1, 0, 8'h03, 0, 0);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after2 got %b want 0", in_ready); end
    step();
    checks++;
    if (a_valid !== 1'b1 || a_data !== 8'h01) begin errors++; $display("FAIL bp_hold got av=%b ad=%h want av=1 ad=01", a_valid, a_data); end
    drive(1, 0, 8'h03, 1, 0);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_pop_ready got %b want 0", in_ready); end
    step();
    checks++;
    if (a_data !== 8'h02 || a_data !== qa[0]) begin errors++; $display("FAIL bp_order2 got %h want 02", a_data); end
    drive(1, 0, 8'h03, 1, 0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %b want 1", in_ready); end
    step();
    checks++;
    if (a_valid !== 1'b1 || a_data !== 8'h03) begin errors++; $display("FAIL bp_order3 got av=%b ad=%h want av=1 ad=03", a_valid, a_data); end
    drive(0, 0, 0, 1, 0);
    step();
    checks++;
    if (a_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got av=%b want 0", a_valid); end
  endtask
  task automatic test_isolation();
    drive(1, 0, 8'hA1, 0, 0);
    step();
    drive(1, 0, 8'hA2, 0, 0);
    step();
    drive(1, 1, 8'hB0, 0, 0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL iso_in_ready got %b want 1", in_ready); end
    step();
    checks++;
    if (b_valid !== 1'b1 || b_data !== 8'hB0 || a_data !== 8'hA1) begin
      errors++;
      $display("FAIL iso_data got bv=%b bd=%h ad=%h want bv=1 bd=b0 ad=a1", b_valid, b_data, a_data);
    end
  endtask
  task automatic test_async_reset();
    drive(0, 0, 0, 0, 0);
    #2;
    reset = 1;
    #1;
    checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin errors++; $display("FAIL async_reset got av=%b bv=%b want 0 0", a_valid, b_valid); end
    @(posedge clk);
    #1;
    reset = 0;
    qa.delete();
    qb.delete();
    na = 0;
    nb = 0;
    checks++;
    if (in_ready !== 1'b1 || a_count !== 4'd0 || b_count !== 4'd0 || a_data !== 8'd0) begin
      errors++;
      $display("FAIL async_release got rdy=%b ac=%h bc=%h ad=%h want 1 0 0 00", in_ready, a_count, b_count, a_data);
    end
  endtask
  task automatic test_streaming();
    for (int i = 0; i < 100; i++) begin
      drive(1, i[0], 8'($urandom), 1, 1);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready cycle %0d got %b want 1", i, in_ready); end
      step();
      checks++;
      if (a_valid !== (qa.size() > 0) || b_valid !== (qb.size() > 0) ||
          (qa.size() > 0 && a_data !== qa[0]) || (qb.size() > 0 && b_data !== qb[0])) begin
        errors++;
        $display("FAIL stream_out cycle %0d got av=%b ad=%h bv=%b bd=%h want qa=%0d qb=%0d", i, a_valid, a_data, b_valid, b_data, qa.size(), qb.size());
      end
    end
    drive(0, 0, 0, 1, 1);
    step();
  endtask
  task automatic test_random();
    bit exp_rdy;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0);
      exp_rdy = in_sel ? qb.size() < 2 : qa.size() < 2;
      checks++;
      if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready cycle %0d got %b want %b", i, in_ready, exp_rdy); end
      step();
      checks++;
      if (a_valid !== (qa.size() > 0) || b_valid !== (qb.size() > 0) ||
          (qa.size() > 0 && a_data !== qa[0]) || (qb.size() > 0 && b_data !== qb[0]) ||
          a_count !== exp_cnt(na) || b_count !== exp_cnt(nb)) begin
        errors++;
        $display("FAIL rand_out cycle %0d got av=%b ad=%h bv=%b bd=%h ac=%h bc=%h want qa=%0d qb=%0d ac=%h bc=%h",
                 i, a_valid, a_data, b_valid, b_data, a_count, b_count, qa.size(), qb.size(), exp_cnt(na), exp_cnt(nb));
      end
    end
  endtask
  task automatic test_counters();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 8'(i), 1, 0);
      step();
    end
    drive(0, 0, 0, 1, 0);
    repeat (2) step();
    checks++;
    if (na != 17 || a_count !== (CNT_EN ? 4'd1 : 4'd0) || b_count !== 4'd0) begin
      errors++;
      $display("FAIL count_wrap got delivered=%0d ac=%h bc=%h want delivered=17 ac=%h bc=0", na, a_count, b_count, CNT_EN ? 4'd1 : 4'd0);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_pressure();
    test_isolation();
    test_async_reset();
    test_streaming();
    test_random();
    test_counters();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
